// File: rtl/rns2bin_sched.sv
// rns2bin_sched: round-robin scheduler sharing one RNS(32,31,21,5)-to-binary converter among N_REQ requesters
// Ports: clk/reset (async, active high); cfg_start/cfg_busy/conv_rst sequence the converter matrix load;
// req_valid/req_ready/req_res carry per-requester residue words {x3,x2,x1,x0}; conv_x0..3/conv_n drive and
// sample the converter; resp_valid/resp_ready/resp_id/resp_data/resp_err return the tagged 18-bit result;
// conv_count counts good conversions.
module rns2bin_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2,
  parameter int CONV_LAT = 2,
  parameter int CFG_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  output logic                  cfg_busy,
  output logic                  conv_rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*20-1:0]   req_res,
  output logic [4:0]            conv_x0,
  output logic [4:0]            conv_x1,
  output logic [4:0]            conv_x2,
  output logic [4:0]            conv_x3,
  input  logic [17:0]           conv_n,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [17:0]           resp_data,
  output logic                  resp_err,
  output logic [15:0]           conv_count
);
  typedef enum logic [2:0] {IDLE, CFG, ARB, WAIT, RESP} state_t;
  state_t state;
  logic cfg_pending, configured, any, res_ok;
  logic [ID_W-1:0] rr, g, idx;
  logic [3:0] cnt;
  logic [19:0] res;
  // scan downward so the last hit is the first valid requester at or after rr
  always_comb begin
    g = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr) + i) % N_REQ);
      if (req_valid[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    res = '0;
    for (int i = 0; i < N_REQ; i++)
      if (g == ID_W'(i)) res = req_res[i*20 +: 20];
  end
  // x0 is 5 bits so it is always below 32
  assign res_ok = res[9:5] < 5'd31 && res[14:10] < 5'd21 && res[19:15] < 5'd5;
  assign req_ready = (state == ARB && any) ? N_REQ'(1) << g : '0;
  assign cfg_busy = state == CFG;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cfg_pending <= 1'b0;
      configured <= 1'b0;
      rr <= '0;
      cnt <= '0;
      conv_rst <= 1'b0;
      conv_x0 <= '0;
      conv_x1 <= '0;
      conv_x2 <= '0;
      conv_x3 <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
      conv_count <= '0;
    end else begin
      if (cfg_start) cfg_pending <= 1'b1;
      case (state)
        IDLE:
          if (cfg_pending) begin
            state <= CFG;
            cfg_pending <= cfg_start;
            conv_rst <= 1'b1;
            cnt <= 4'(CFG_CYCLES - 1);
          end else if (configured && |req_valid) state <= ARB;
        CFG:
          if (cnt == '0) begin
            state <= IDLE;
            conv_rst <= 1'b0;
            configured <= 1'b1;
          end else cnt <= cnt - 4'd1;
        ARB:
          if (!any) state <= IDLE;
          else begin
            resp_id <= g;
            rr <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
            if (res_ok) begin
              conv_x0 <= res[4:0];
              conv_x1 <= res[9:5];
              conv_x2 <= res[14:10];
              conv_x3 <= res[19:15];
              cnt <= 4'(CONV_LAT - 1);
              state <= WAIT;
            end else begin
              resp_err <= 1'b1;
              resp_data <= '0;
              state <= RESP;
            end
          end
        WAIT:
          if (cnt == '0) begin
            resp_data <= conv_n;
            resp_err <= 1'b0;
            resp_valid <= 1'b1;
            conv_count <= conv_count + 16'd1;
            state <= RESP;
          end else cnt <= cnt - 4'd1;
        RESP:
          // error responses arrive here with resp_valid low and raise it one edge later
          if (!resp_valid) resp_valid <= 1'b1;
          else if (resp_ready) begin
            resp_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_rns2bin_sched.sv
// tb_rns2bin_sched: scoreboard bench for rns2bin_sched with a behavioural one-stage RNS converter
module tb_rns2bin_sched;
  logic clk = 1'b0, reset = 1'b1, cfg_start = 1'b0, resp_ready = 1'b1;
  logic cfg_busy, conv_rst, resp_valid, resp_err;
  logic [3:0] req_valid = '0, req_ready;
  logic [79:0] req_res = '0;
  logic [4:0] conv_x0, conv_x1, conv_x2, conv_x3;
  logic [17:0] conv_n = '0, resp_data;
  logic [1:0] resp_id;
  logic [15:0] conv_count;
  logic loaded = 1'b0;
  int n_tests = 0, n_fail = 0, hs_cnt = 0;
  typedef struct {logic [1:0] id; logic [17:0] data; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  rns2bin_sched dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_busy(cfg_busy), .conv_rst(conv_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_res(req_res),
    .conv_x0(conv_x0), .conv_x1(conv_x1), .conv_x2(conv_x2), .conv_x3(conv_x3), .conv_n(conv_n),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .conv_count(conv_count)
  );
  function automatic logic [17:0] crt(input logic [4:0] a0, a1, a2, a3);
    for (int n = int'(a0); n < 104160; n += 32)
      if (n % 31 == int'(a1) && n % 21 == int'(a2) && n % 5 == int'(a3)) return 18'(n);
    return '1;
  endfunction
  always @(posedge clk) begin
    if (conv_rst) loaded <= 1'b1;
    conv_n <= loaded ? crt(conv_x0, conv_x1, conv_x2, conv_x3) : 18'h3ffff;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (|(req_ready & req_valid)) hs_cnt <= hs_cnt + 1;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) check("unexpected_resp", 32'(resp_id), 32'hffff_ffff);
      else begin
        e = sb.pop_front();
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_data", 32'(resp_data), 32'(e.data));
        check("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [1:0] id, input logic [17:0] data, input logic err);
    sb.push_back('{id, data, err});
  endtask
  task automatic cfg_pulse();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask
  // drive a request and return 1ns after its handshake edge
  task automatic send(input int id, input logic [4:0] a0, a1, a2, a3);
    req_res[id*20 +: 20] = {a3, a2, a1, a0};
    req_valid[id] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (req_ready[id]) begin
        tick();
        req_valid[id] = 1'b0;
        return;
      end
      tick();
    end
    req_valid[id] = 1'b0;
    check("grant_timeout", 0, 1);
  endtask
  task automatic wait_resp();
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) return;
      tick();
    end
    check("resp_timeout", 0, 1);
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !resp_valid) return;
      tick();
    end
    check("drain_timeout", 32'(sb.size()), 0);
  endtask
  initial begin
    int hi, base;
    tick();
    check("rst_conv_rst", 32'(conv_rst), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_count", 32'(conv_count), 0);
    tick();
    reset = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ready_preconfig", 32'(req_ready), 0);
    end
    req_valid[0] = 1'b0;
    cfg_pulse();
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (conv_rst) hi++;
      check("cfg_busy_vs_rst", 32'(cfg_busy), 32'(conv_rst));
    end
    check("cfg_len", 32'(hi), 2);
    push(2'd1, 18'd12345, 1'b0);
    send(1, 5'd25, 5'd7, 5'd18, 5'd0);
    check("x0", 32'(conv_x0), 25);
    check("x1", 32'(conv_x1), 7);
    check("x2", 32'(conv_x2), 18);
    check("x3", 32'(conv_x3), 0);
    check("lat_e0", 32'(resp_valid), 0);
    tick();
    check("lat_e1", 32'(resp_valid), 0);
    tick();
    check("lat_e2", 32'(resp_valid), 1);
    check("good_data", 32'(resp_data), 12345);
    check("good_count", 32'(conv_count), 1);
    wait_drain();
    resp_ready = 1'b0;
    push(2'd2, 18'd104159, 1'b0);
    push(2'd3, 18'd12345, 1'b0);
    req_res[60 +: 20] = {5'd0, 5'd18, 5'd7, 5'd25};
    req_valid[3] = 1'b1;
    send(2, 5'd31, 5'd30, 5'd20, 5'd4);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      cfg_start = i == 1;
      tick();
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_id", 32'(resp_id), 2);
      check("hold_data", 32'(resp_data), 104159);
      check("hold_no_cfg", 32'(conv_rst), 0);
    end
    cfg_start = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("accept_drop", 32'(resp_valid), 0);
    tick();
    check("cfg_first", 32'(cfg_busy), 1);
    check("cfg_blocks", 32'(req_ready), 0);
    send(3, 5'd25, 5'd7, 5'd18, 5'd0);
    wait_drain();
    push(2'd0, 18'd0, 1'b0);
    push(2'd2, 18'd104159, 1'b0);
    push(2'd3, 18'd12345, 1'b0);
    push(2'd0, 18'd0, 1'b0);
    req_res = {5'd0, 5'd18, 5'd7, 5'd25, 5'd4, 5'd20, 5'd30, 5'd31, 20'd0, 20'd0};
    base = hs_cnt;
    req_valid = 4'b1101;
    for (int i = 0; i < 200 && hs_cnt < base + 4; i++) tick();
    req_valid = '0;
    check("rr_handshakes", 32'(hs_cnt - base), 4);
    wait_drain();
    check("rr_count", 32'(conv_count), 7);
    push(2'd0, 18'd0, 1'b1);
    send(0, 5'd0, 5'd31, 5'd0, 5'd0);
    check("err_lat_e0", 32'(resp_valid), 0);
    tick();
    check("err_lat_e1", 32'(resp_valid), 1);
    check("err_flag", 32'(resp_err), 1);
    check("err_data", 32'(resp_data), 0);
    check("err_x1_kept", 32'(conv_x1), 0);
    check("err_count", 32'(conv_count), 7);
    wait_drain();
    send(1, 5'd25, 5'd7, 5'd18, 5'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_x0", 32'(conv_x0), 0);
    check("mid_rst_valid", 32'(resp_valid), 0);
    check("mid_rst_count", 32'(conv_count), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b0;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ready_unconfigured", 32'(req_ready), 0);
    end
    cfg_pulse();
    push(2'd1, 18'd12345, 1'b0);
    send(1, 5'd25, 5'd7, 5'd18, 5'd0);
    wait_drain();
    check("final_count", 32'(conv_count), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
